// File: rtl/pwm_dt_pkg.sv
// Shared types and default sizing for the dead-time PWM core.
package pwm_dt_pkg;

    localparam int unsigned NOutputsDef   = 6;
    localparam int unsigned PhaseCntDwDef = 16;
    localparam int unsigned BeatCntDwDef  = 27;
    localparam int unsigned DtDwDef       = 8;

    // Per-channel dead-time states; p/n drive noted per state
    typedef enum logic [2:0] {
        DT_IDLE = 3'd0,  // p0 n0
        DT_OFF  = 3'd1,  // p0 n1
        DT_RISE = 3'd2,  // p0 n0
        DT_ON   = 3'd3,  // p1 n0
        DT_FALL = 3'd4   // p0 n0
    } dt_state_e;

endpackage

// File: rtl/pwm_dt_chan.sv
// One PWM channel: registered compare, dead-time FSM and output polarity.
module pwm_dt_chan
    import pwm_dt_pkg::*;
#(
    parameter int unsigned PhaseCntDw = PhaseCntDwDef,
    parameter int unsigned DtDw       = DtDwDef
) (
    input  logic                  clk_core_i,
    input  logic                  rst_core_ni,
    input  logic                  chan_en_i,
    input  logic                  invert_i,
    input  logic [DtDw-1:0]       dead_time_i,
    input  logic [PhaseCntDw-1:0] phase_i,
    input  logic [PhaseCntDw-1:0] duty_i,
    output logic                  pwm_o,
    output logic                  pwm_n_o
);

    logic            raw_q;
    dt_state_e       state_q, state_d;
    logic [DtDw-1:0] cnt_q;
    logic [DtDw-1:0] dt_q;     // dead time captured on state entry
    logic            p_q, n_q;
    logic            cnt_done;

    // A zero captured dead time means the dwell ends immediately
    assign cnt_done = (dt_q == '0) || (cnt_q == dt_q - DtDw'(1));

    // Registered compare of the shared phase against this channel's duty
    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) raw_q <= 1'b0;
        else              raw_q <= chan_en_i & (phase_i < duty_i);
    end

    // Next-state selection; disabling the channel overrides everything
    always_comb begin
        state_d = state_q;
        if (!chan_en_i) begin
            state_d = DT_IDLE;
        end else begin
            unique case (state_q)
                DT_IDLE: state_d = DT_FALL;
                DT_OFF:  if (raw_q) state_d = (dead_time_i == '0) ? DT_ON : DT_RISE;
                DT_RISE: if (!raw_q) state_d = DT_OFF;
                         else if (cnt_done) state_d = DT_ON;
                DT_ON:   if (!raw_q) state_d = (dead_time_i == '0) ? DT_OFF : DT_FALL;
                DT_FALL: if (raw_q) state_d = DT_ON;
                         else if (cnt_done) state_d = DT_OFF;
                default: state_d = DT_IDLE;
            endcase
        end
    end

    // State, dwell counter and p/n bits; p/n derived from the next state so they are registered
    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) begin
            state_q <= DT_IDLE;
            cnt_q   <= '0;
            dt_q    <= '0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
                dt_q  <= dead_time_i;
            end else if (state_q == DT_RISE || state_q == DT_FALL) begin
                cnt_q <= cnt_q + DtDw'(1);
            end
            p_q <= (state_d == DT_ON);
            n_q <= (state_d == DT_OFF);
        end
    end

    assign pwm_o   = p_q ^ invert_i;
    assign pwm_n_o = n_q ^ invert_i;

endmodule

// File: rtl/pwm_dt_core.sv
// PWM core: beat divider, edge/center phase counter, duty shadowing, channels.
module pwm_dt_core
    import pwm_dt_pkg::*;
#(
    parameter int unsigned NOutputs   = NOutputsDef,
    parameter int unsigned PhaseCntDw = PhaseCntDwDef,
    parameter int unsigned BeatCntDw  = BeatCntDwDef,
    parameter int unsigned DtDw       = DtDwDef
) (
    input  logic                           clk_core_i,
    input  logic                           rst_core_ni,
    input  logic                           cntr_en_i,
    input  logic [BeatCntDw-1:0]           clk_div_i,
    input  logic [3:0]                     dc_resn_i,
    input  logic                           center_en_i,
    input  logic                           cfg_qe_i,
    input  logic [NOutputs-1:0]            chan_en_i,
    input  logic [NOutputs-1:0]            invert_i,
    input  logic [NOutputs*PhaseCntDw-1:0] duty_i,
    input  logic [DtDw-1:0]                dead_time_i,
    input  logic                           commit_i,
    output logic                           commit_pending_o,
    output logic                           commit_done_o,
    output logic                           cycle_end_o,
    output logic [NOutputs-1:0]            pwm_o,
    output logic [NOutputs-1:0]            pwm_n_o
);

    localparam int unsigned ResnMax = PhaseCntDw - 1;

    logic [BeatCntDw-1:0]                 beat_q;
    logic [PhaseCntDw-1:0]                phase_q, incr, diff;
    logic [PhaseCntDw:0]                  sum;
    logic                                 dir_down_q;
    logic                                 beat_end, carry, load;
    logic [NOutputs-1:0][PhaseCntDw-1:0]  duty_pend, duty_act_q;

    assign beat_end = (beat_q == clk_div_i) & cntr_en_i;
    assign sum      = {1'b0, phase_q} + {1'b0, incr};
    assign carry    = sum[PhaseCntDw];
    assign diff     = phase_q - incr;
    assign duty_pend = duty_i;

    // Step size shrinks as resolution grows; resolution saturates at the counter width
    always_comb begin
        incr = PhaseCntDw'(1);
        if (32'(dc_resn_i) <= ResnMax) incr = PhaseCntDw'(1) << (ResnMax - 32'(dc_resn_i));
    end

    // Period ends on edge-mode wrap, or on the valley beat while counting down
    assign cycle_end_o = center_en_i ? (beat_end & dir_down_q & (phase_q == '0))
                                     : (beat_end & carry);

    // Beat divider; a config write restarts it
    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni)   beat_q <= '0;
        else if (cfg_qe_i)  beat_q <= '0;
        else if (cntr_en_i) beat_q <= (beat_q == clk_div_i) ? '0 : beat_q + BeatCntDw'(1);
    end

    // Phase counter; direction only matters in center mode and survives mode switches
    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) begin
            phase_q    <= '0;
            dir_down_q <= 1'b0;
        end else if (cfg_qe_i) begin
            phase_q    <= '0;
            dir_down_q <= 1'b0;
        end else if (beat_end) begin
            if (!center_en_i) begin
                phase_q <= sum[PhaseCntDw-1:0];
            end else if (!dir_down_q) begin
                if (carry) begin
                    dir_down_q <= 1'b1;
                    phase_q    <= diff;
                end else begin
                    phase_q <= sum[PhaseCntDw-1:0];
                end
            end else if (phase_q == '0) begin
                dir_down_q <= 1'b0;
                phase_q    <= sum[PhaseCntDw-1:0];
            end else begin
                phase_q <= diff;
            end
        end
    end

    // Duty shadowing: load at period boundary, or at once while the counter is stopped
    assign load = (commit_i | commit_pending_o) & (cycle_end_o | ~cntr_en_i);

    // Commit handshake and active duty registers
    always_ff @(posedge clk_core_i or negedge rst_core_ni) begin
        if (!rst_core_ni) begin
            commit_pending_o <= 1'b0;
            commit_done_o    <= 1'b0;
            duty_act_q       <= '0;
        end else begin
            commit_pending_o <= load ? 1'b0 : (commit_pending_o | commit_i);
            commit_done_o    <= load;
            if (load) duty_act_q <= duty_pend;
        end
    end

    for (genvar k = 0; k < NOutputs; k++) begin : g_chan
        pwm_dt_chan #(
            .PhaseCntDw (PhaseCntDw),
            .DtDw       (DtDw)
        ) u_chan (
            .clk_core_i  (clk_core_i),
            .rst_core_ni (rst_core_ni),
            .chan_en_i   (chan_en_i[k]),
            .invert_i    (invert_i[k]),
            .dead_time_i (dead_time_i),
            .phase_i     (phase_q),
            .duty_i      (duty_act_q[k]),
            .pwm_o       (pwm_o[k]),
            .pwm_n_o     (pwm_n_o[k])
        );
    end

endmodule
